// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, E-stage redirect flush and
// multi-cycle LSU wait-state handling with timeout, plus saturating event counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic [4:0]       rd_addr_E,
  input  logic             rd_wren_E,
  input  logic             is_load_E,
  input  logic             redirect_E,
  input  logic             mem_access_M,
  input  logic             mem_ack_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_redirect,
  output logic [CNT_W-1:0] cnt_mem_wait
);

  // A zero timeout still needs a one-bit counter so the declarations stay legal.
  localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;

  logic rs1_hit, rs2_hit, lu_hit;
  logic timeout_hit, mem_stall;
  logic act_lu, act_redirect;
  logic [2:0] cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_all;

  always_comb begin
    rs1_hit     = rs1_used_D & (rs1_addr_D == rd_addr_E);
    rs2_hit     = rs2_used_D & (rs2_addr_D == rd_addr_E);
    lu_hit      = is_load_E & rd_wren_E & (rd_addr_E != 5'd0) & (rs1_hit | rs2_hit);
    timeout_hit = (MEM_TIMEOUT != 0) && (state_q == MEM_WAIT) &&
                  (wait_cnt_q == WC_W'(MEM_TIMEOUT));
    mem_stall   = mem_access_M & ~mem_ack_M & ~timeout_hit;
  end

  // Priority resolution; reset masks every control so the pipeline drains cleanly.
  always_comb begin
    stall_F      = 1'b0;
    stall_D      = 1'b0;
    stall_E      = 1'b0;
    stall_M      = 1'b0;
    flush_D      = 1'b0;
    flush_E      = 1'b0;
    act_lu       = 1'b0;
    act_redirect = 1'b0;
    if (!i_rst) begin
      if (mem_stall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
      end else if (redirect_E) begin
        flush_D      = 1'b1;
        flush_E      = 1'b1;
        act_redirect = 1'b1;
      end else if (lu_hit) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
        act_lu  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        // A vanished access (e.g. the M instruction got killed) ends the wait quietly.
        if (mem_ack_M || !mem_access_M) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign cnt_inc = {mem_stall & ~i_rst, act_redirect, act_lu};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_all[gi] = cnt_q;
    end
  endgenerate

  assign cnt_load_use = cnt_all[0];
  assign cnt_redirect = cnt_all[1];
  assign cnt_mem_wait = cnt_all[2];
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one wide-counter instance with a short timeout
// and a 2-bit-counter twin on the same inputs for saturation.
module tb_hazard_ctrl;

  logic        clk;
  logic        i_rst;
  logic [4:0]  rs1_addr_D, rs2_addr_D, rd_addr_E;
  logic        rs1_used_D, rs2_used_D, rd_wren_E, is_load_E;
  logic        redirect_E, mem_access_M, mem_ack_M;

  logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_err;
  logic [15:0] cnt_load_use, cnt_redirect, cnt_mem_wait;

  logic        s2_stall_F, s2_stall_D, s2_stall_E, s2_stall_M, s2_flush_D, s2_flush_E, s2_mem_err;
  logic [1:0]  s2_cnt_load_use, s2_cnt_redirect, s2_cnt_mem_wait;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
    .rd_addr_E(rd_addr_E), .rd_wren_E(rd_wren_E), .is_load_E(is_load_E),
    .redirect_E(redirect_E), .mem_access_M(mem_access_M), .mem_ack_M(mem_ack_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .mem_err(mem_err),
    .cnt_load_use(cnt_load_use), .cnt_redirect(cnt_redirect), .cnt_mem_wait(cnt_mem_wait)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(i_rst),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
    .rd_addr_E(rd_addr_E), .rd_wren_E(rd_wren_E), .is_load_E(is_load_E),
    .redirect_E(redirect_E), .mem_access_M(mem_access_M), .mem_ack_M(mem_ack_M),
    .stall_F(s2_stall_F), .stall_D(s2_stall_D), .stall_E(s2_stall_E), .stall_M(s2_stall_M),
    .flush_D(s2_flush_D), .flush_E(s2_flush_E), .mem_err(s2_mem_err),
    .cnt_load_use(s2_cnt_load_use), .cnt_redirect(s2_cnt_redirect), .cnt_mem_wait(s2_cnt_mem_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control vector order: {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}, {26'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_addr_D = 5'd0; rs2_addr_D = 5'd0; rs1_used_D = 1'b0; rs2_used_D = 1'b0;
    rd_addr_E = 5'd0; rd_wren_E = 1'b0; is_load_E = 1'b0;
    redirect_E = 1'b0; mem_access_M = 1'b0; mem_ack_M = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    is_load_E = 1'b1; rd_wren_E = 1'b1; rd_addr_E = rd;
    rs1_used_D = 1'b1; rs1_addr_D = rd;
  endtask

  initial begin
    clr();
    i_rst = 1'b1;
    mem_access_M = 1'b1;
    #1;
    chk_ctl("rst_forces_ctl0", 6'b000000);
    tick();
    tick();
    chk_ctl("rst_forces_ctl0_b", 6'b000000);
    i_rst = 1'b0;
    clr();
    #1;
    chk("rst_cnt_lu", cnt_load_use, 0);
    chk("rst_cnt_rd", cnt_redirect, 0);
    chk("rst_cnt_mw", cnt_mem_wait, 0);
    chk("rst_err", mem_err, 0);
    chk_ctl("idle_ctl", 6'b000000);

    // Load-use on rs1
    set_lu(5'd5);
    #1;
    chk_ctl("lu_rs1_ctl", 6'b110001);
    tick();
    clr();
    #1;
    chk_ctl("lu_one_bubble", 6'b000000);
    chk("lu_cnt1", cnt_load_use, 1);
    // Load-use on rs2
    is_load_E = 1'b1; rd_wren_E = 1'b1; rd_addr_E = 5'd7;
    rs2_used_D = 1'b1; rs2_addr_D = 5'd7; rs1_addr_D = 5'd7;
    #1;
    chk_ctl("lu_rs2_ctl", 6'b110001);
    tick();
    clr();
    // rd = x0 never interlocks
    set_lu(5'd0);
    #1;
    chk_ctl("lu_x0_ctl", 6'b000000);
    tick();
    chk("lu_x0_cnt", cnt_load_use, 2);
    // Address match but register not used
    set_lu(5'd9);
    rs1_used_D = 1'b0;
    #1;
    chk_ctl("lu_unused_ctl", 6'b000000);
    // Match but E is not a load
    rs1_used_D = 1'b1; is_load_E = 1'b0;
    #1;
    chk_ctl("lu_notload_ctl", 6'b000000);
    tick();
    chk("lu_nohit_cnt", cnt_load_use, 2);
    clr();

    // Redirect beats load-use
    set_lu(5'd3);
    redirect_E = 1'b1;
    #1;
    chk_ctl("redir_vs_lu_ctl", 6'b000011);
    tick();
    clr();
    #1;
    chk("redir_cnt", cnt_redirect, 1);
    chk("redir_lu_cnt", cnt_load_use, 2);

    // Memory wait: ack three cycles late
    mem_access_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl($sformatf("memwait_stall_%0d", i), 6'b111100);
      tick();
    end
    mem_ack_M = 1'b1;
    #1;
    chk_ctl("memwait_ack_ctl", 6'b000000);
    tick();
    chk("memwait_cnt", cnt_mem_wait, 3);
    // Zero-wait access right after: no stall, no count
    #1;
    chk_ctl("zero_wait_ctl", 6'b000000);
    tick();
    chk("zero_wait_cnt", cnt_mem_wait, 3);
    clr();

    // Timeout: four stalled cycles, released on the fifth
    mem_access_M = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ctl($sformatf("tmo_stall_%0d", i), 6'b111100);
      tick();
    end
    #1;
    chk_ctl("tmo_release_ctl", 6'b000000);
    chk("tmo_err_before", mem_err, 0);
    tick();
    chk("tmo_err_set", mem_err, 1);
    chk("tmo_cnt", cnt_mem_wait, 7);
    clr();
    tick();
    tick();
    chk("tmo_err_sticky", mem_err, 1);

    // Redirect held off by a two-cycle memory stall
    mem_access_M = 1'b1;
    redirect_E = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_ctl($sformatf("defer_stall_%0d", i), 6'b111100);
      tick();
    end
    mem_ack_M = 1'b1;
    #1;
    chk_ctl("defer_flush_ctl", 6'b000011);
    tick();
    chk("defer_redir_cnt", cnt_redirect, 2);
    chk("defer_mw_cnt", cnt_mem_wait, 9);
    clr();

    // Reset in the middle of a memory wait
    mem_access_M = 1'b1;
    tick();
    tick();
    i_rst = 1'b1;
    #1;
    chk_ctl("rst_midwait_ctl", 6'b000000);
    tick();
    i_rst = 1'b0;
    clr();
    #1;
    chk("rst2_cnt_lu", cnt_load_use, 0);
    chk("rst2_cnt_rd", cnt_redirect, 0);
    chk("rst2_cnt_mw", cnt_mem_wait, 0);
    chk("rst2_err", mem_err, 0);
    chk_ctl("rst2_ctl", 6'b000000);

    // Saturation of the 2-bit twin over five load-use bubbles
    for (int i = 0; i < 5; i++) begin
      set_lu(5'd12);
      tick();
      clr();
      tick();
      if (i == 2) chk("sat_at3", s2_cnt_load_use, 3);
      if (i == 3) chk("sat_no_wrap", s2_cnt_load_use, 3);
    end
    chk("sat_final", s2_cnt_load_use, 3);
    chk("wide_lu_5", cnt_load_use, 5);

    // Access withdrawn mid-wait: back to RUN, no error, timer restarts
    mem_access_M = 1'b1;
    tick();
    tick();
    mem_access_M = 1'b0;
    #1;
    chk_ctl("drop_ctl", 6'b000000);
    tick();
    chk("drop_no_err", mem_err, 0);
    chk("drop_mw_cnt", cnt_mem_wait, 2);
    mem_access_M = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ctl($sformatf("drop_restart_stall_%0d", i), 6'b111100);
      tick();
    end
    #1;
    chk_ctl("drop_restart_release", 6'b000000);
    tick();
    chk("drop_restart_err", mem_err, 1);
    clr();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
